// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, presents it to the I-cache, and queues
// each hit {inst, pc} in a FIFO that dispatch drains with a valid/ready handshake.
`ifndef XLEN
`define XLEN 32
`endif

module fetch_stage #(
  parameter int                FB_DEPTH = 8,
  parameter logic [`XLEN-1:0]  RESET_PC = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [31:0]                   Icache2proc_data,
  input  logic                          Icache2proc_valid,
  output logic [`XLEN-1:0]              proc2Icache_addr,
  input  logic                          redirect_valid,
  input  logic [`XLEN-1:0]              redirect_pc,
  input  logic                          dispatch_ready,
  output logic                          if_valid,
  output logic [31:0]                   if_inst,
  output logic [`XLEN-1:0]              if_pc,
  output logic [`XLEN-1:0]              if_npc,
  output logic [$clog2(FB_DEPTH+1)-1:0] fb_count,
  output logic                          fb_full
);

  localparam int XLEN = `XLEN;
  localparam int PW   = $clog2(FB_DEPTH);
  localparam int CW   = $clog2(FB_DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FB_DEPTH);

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

  // Wraps modulo 2^XLEN, so the last word of the address space steps to 0.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] a);
    return a + XLEN'(4);
  endfunction

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic [31:0]     inst_mem_q [FB_DEPTH];
  logic [XLEN-1:0] pc_mem_q   [FB_DEPTH];

  logic empty;
  logic pop;
  logic fire;

  assign empty    = (count_q == '0);
  assign if_valid = !empty && !redirect_valid;
  assign pop      = if_valid && dispatch_ready;
  // A simultaneous pop frees the slot this push needs, so a full buffer can still fire.
  assign fire     = Icache2proc_valid && !redirect_valid && ((count_q < DEPTH_C) || pop);

  assign proc2Icache_addr = pc_q;
  assign fb_count         = count_q;
  assign fb_full          = (count_q == DEPTH_C);

  assign if_inst = empty ? '0 : inst_mem_q[head_q];
  assign if_pc   = empty ? '0 : pc_mem_q[head_q];
  assign if_npc  = empty ? '0 : pc_inc(pc_mem_q[head_q]);

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d    = word_align(redirect_pc);
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (fire) begin
        pc_d   = pc_inc(pc_q);
        tail_d = tail_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      if (fire && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !fire) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= word_align(RESET_PC);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is never reset; occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (fire) begin
      inst_mem_q[tail_q] <= Icache2proc_data;
      pc_mem_q[tail_q]   <= pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus queues expected entries, a monitor
// compares every dispatched entry in order.
module tb_fetch_stage;

  logic        clock;
  logic        reset;
  logic [31:0] Icache2proc_data;
  logic        Icache2proc_valid;
  logic [31:0] proc2Icache_addr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dispatch_ready;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic [31:0] if_npc;
  logic [3:0]  fb_count;
  logic        fb_full;

  fetch_stage #(.FB_DEPTH(8), .RESET_PC(32'h0)) dut (
    .clock             (clock),
    .reset             (reset),
    .Icache2proc_data  (Icache2proc_data),
    .Icache2proc_valid (Icache2proc_valid),
    .proc2Icache_addr  (proc2Icache_addr),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .dispatch_ready    (dispatch_ready),
    .if_valid          (if_valid),
    .if_inst           (if_inst),
    .if_pc             (if_pc),
    .if_npc            (if_npc),
    .fb_count          (fb_count),
    .fb_full           (fb_full)
  );

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } entry_t;

  entry_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void expect_entry(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] npc);
    entry_t e;
    e.inst = inst;
    e.pc   = pc;
    e.npc  = npc;
    exp_q.push_back(e);
  endfunction

  // Inputs change at the falling edge; everything is sampled 1 time unit later.
  task automatic drive(input logic v, input logic [31:0] d, input logic rdy,
                       input logic rv, input logic [31:0] rpc, input logic rst);
    @(negedge clock);
    reset             = rst;
    Icache2proc_valid = v;
    Icache2proc_data  = d;
    dispatch_ready    = rdy;
    redirect_valid    = rv;
    redirect_pc       = rpc;
    if (rv || rst) exp_q.delete();
    #1;
  endtask

  // Monitor: every handshake that will pop must match the oldest expected entry.
  initial begin
    entry_t e;
    forever begin
      @(negedge clock);
      #1;
      if (if_valid === 1'b1 && dispatch_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pop: got pc %h with no entry expected", if_pc);
        end else begin
          e = exp_q.pop_front();
          check("pop_inst", if_inst, e.inst);
          check("pop_pc",   if_pc,   e.pc);
          check("pop_npc",  if_npc,  e.npc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; Icache2proc_valid = 1'b0; Icache2proc_data = '0;
    dispatch_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    check("rst_addr",  proc2Icache_addr, 32'h0);
    check("rst_count", {28'h0, fb_count}, 32'd0);
    check("rst_valid", {31'h0, if_valid}, 32'd0);
    check("rst_full",  {31'h0, fb_full},  32'd0);
    check("rst_inst",  if_inst, 32'h0);
    check("rst_pc",    if_pc,   32'h0);
    check("rst_npc",   if_npc,  32'h0);

    // Three hits without dispatch
    drive(1, 32'hA, 0, 0, 0, 0); check("t1_addr0", proc2Icache_addr, 32'h0); expect_entry(32'hA, 32'h0, 32'h4);
    drive(1, 32'hB, 0, 0, 0, 0); check("t1_addr4", proc2Icache_addr, 32'h4); expect_entry(32'hB, 32'h4, 32'h8);
    check("t1_cnt1", {28'h0, fb_count}, 32'd1);
    drive(1, 32'hC, 0, 0, 0, 0); check("t1_addr8", proc2Icache_addr, 32'h8); expect_entry(32'hC, 32'h8, 32'hC);
    drive(0, 0, 0, 0, 0, 0);
    check("t1_addr12", proc2Icache_addr, 32'hC);
    check("t1_cnt3",   {28'h0, fb_count}, 32'd3);
    check("t1_hvalid", {31'h0, if_valid}, 32'd1);
    check("t1_hpc",    if_pc,   32'h0);
    check("t1_hinst",  if_inst, 32'hA);
    check("t1_hnpc",   if_npc,  32'h4);

    // Fill to full, then push+pop on a full buffer
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h100 + i, 0, 0, 0, 0);
      check("t2_fill_addr", proc2Icache_addr, 32'hC + 4 * i);
      expect_entry(32'h100 + i, 32'hC + 4 * i, 32'h10 + 4 * i);
    end
    drive(1, 32'hDEAD, 0, 0, 0, 0);
    check("t2_cnt8", {28'h0, fb_count}, 32'd8);
    check("t2_full", {31'h0, fb_full},  32'd1);
    check("t2_hold", proc2Icache_addr,  32'h20);
    drive(1, 32'hDEAD, 0, 0, 0, 0);
    check("t2_hold2", proc2Icache_addr, 32'h20);
    drive(1, 32'h200, 1, 0, 0, 0);
    check("t2_pp_addr", proc2Icache_addr, 32'h20);
    expect_entry(32'h200, 32'h20, 32'h24);
    drive(0, 0, 0, 0, 0, 0);
    check("t2_pp_cnt",  {28'h0, fb_count}, 32'd8);
    check("t2_pp_addr2", proc2Icache_addr, 32'h24);

    // Drain, then stream up to PC 0x40 with dispatch ready
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("t3_drained", {28'h0, fb_count}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      drive(1, 32'h300 + i, 1, 0, 0, 0);
      check("t3_stream_addr", proc2Icache_addr, 32'h24 + 4 * i);
      expect_entry(32'h300 + i, 32'h24 + 4 * i, 32'h28 + 4 * i);
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 32'hBAD, 0, 0, 0, 0);
      check("t3_miss_addr", proc2Icache_addr, 32'h40);
      check("t3_miss_cnt",  {28'h0, fb_count}, 32'd1);
    end
    drive(1, 32'h400, 0, 0, 0, 0);
    check("t3_hit_addr", proc2Icache_addr, 32'h40);
    expect_entry(32'h400, 32'h40, 32'h44);
    drive(0, 0, 0, 0, 0, 0);
    check("t3_hit_cnt",  {28'h0, fb_count}, 32'd2);
    check("t3_hit_addr2", proc2Icache_addr, 32'h44);

    // Redirect with five entries buffered, dispatch ready and a cache hit
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h500 + i, 0, 0, 0, 0);
      expect_entry(32'h500 + i, 32'h44 + 4 * i, 32'h48 + 4 * i);
    end
    drive(0, 0, 0, 0, 0, 0);
    check("t4_cnt5", {28'h0, fb_count}, 32'd5);
    drive(1, 32'h555, 1, 1, 32'h1003, 0);
    check("t4_rd_valid", {31'h0, if_valid}, 32'd0);
    check("t4_rd_cnt",   {28'h0, fb_count}, 32'd5);
    drive(0, 0, 0, 0, 0, 0);
    check("t4_cnt0",  {28'h0, fb_count}, 32'd0);
    check("t4_addr",  proc2Icache_addr, 32'h1000);
    check("t4_valid", {31'h0, if_valid}, 32'd0);
    check("t4_inst",  if_inst, 32'h0);

    // PC wrap at the top of the address space
    drive(0, 0, 0, 1, 32'hFFFF_FFFF, 0);
    drive(1, 32'h777, 0, 0, 0, 0);
    check("t5_addr", proc2Icache_addr, 32'hFFFF_FFFC);
    expect_entry(32'h777, 32'hFFFF_FFFC, 32'h0);
    drive(0, 0, 0, 0, 0, 0);
    check("t5_wrap", proc2Icache_addr, 32'h0);
    check("t5_npc",  if_npc, 32'h0);
    check("t5_pc",   if_pc,  32'hFFFF_FFFC);
    drive(0, 0, 1, 0, 0, 0);

    // Back-to-back redirects: last one wins
    drive(1, 32'h1, 0, 1, 32'h2000, 0);
    drive(1, 32'h2, 0, 1, 32'h3006, 0);
    check("t5_rd1_addr", proc2Icache_addr, 32'h2000);
    drive(0, 0, 0, 0, 0, 0);
    check("t5_rd2_addr", proc2Icache_addr, 32'h3004);
    check("t5_rd2_cnt",  {28'h0, fb_count}, 32'd0);

    // Reset mid-stream overrides a redirect and a hit
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h600 + i, 0, 0, 0, 0);
      expect_entry(32'h600 + i, 32'h3004 + 4 * i, 32'h3008 + 4 * i);
    end
    drive(0, 0, 0, 0, 0, 0);
    check("t6_cnt4", {28'h0, fb_count}, 32'd4);
    drive(1, 32'h666, 1, 1, 32'h5000, 1);
    drive(0, 0, 0, 0, 0, 0);
    check("t6_cnt0",  {28'h0, fb_count}, 32'd0);
    check("t6_valid", {31'h0, if_valid}, 32'd0);
    check("t6_addr",  proc2Icache_addr, 32'h0);

    // Full-rate streaming after reset
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h700 + i, 1, 0, 0, 0);
      expect_entry(32'h700 + i, 4 * i, 4 * i + 4);
    end
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("end_cnt",  {28'h0, fb_count}, 32'd0);
    check("end_addr", proc2Icache_addr, 32'h10);
    check("end_leftover", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
